// File: rtl/alu_mc_pkg.sv
// Shared operation codes and decode helpers for the multi-cycle ALU.
// 4-bit base codes sit in bits[3:0] with bit4 = 0; M ops are {2'b10, funct3}.
package alu_mc_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ALU_OP_W  = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'h00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'h01;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'h02;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'h03;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'h04;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'h05;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'h06;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'h07;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'h08;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'h09;

    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'h10;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'h11;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'h12;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'h13;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'h14;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'h15;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'h16;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'h17;

    function automatic logic is_base_op(input logic [ALU_OP_W-1:0] op);
        return (op[4] == 1'b0) && (op[3:0] <= ALU_AND[3:0]);
    endfunction

    function automatic logic is_m_op(input logic [ALU_OP_W-1:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative RV32M unit: radix-2 shift-add multiply / restoring divide on magnitudes,
// one bit per cycle. done pulses in the cycle of the last iteration with the signed result.
module alu_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [2:0]       f3;
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] hi, lo, b;
    logic [WIDTH-1:0] hi_n, lo_n;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;

    // MUL/MULH/DIV/REM treat both operands as signed; MULHSU only op1.
    always_comb begin
        a_signed = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
        b_signed = a_signed && (funct3 != 3'd2);
        a_neg    = a_signed & op1[WIDTH-1];
        b_neg    = b_signed & op2[WIDTH-1];
        a_mag    = a_neg ? -op1 : op1;
        b_mag    = b_neg ? -op2 : op2;
    end

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        diff   = rem_sh - {1'b0, b};
        if (f3[2]) begin
            if (!diff[WIDTH]) begin
                hi_n = diff[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = rem_sh[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up on the final iteration's values; divide-by-zero never negates the quotient.
    always_comb begin
        prod = {hi_n, lo_n};
        if (sign_q) prod = -prod;
        case (f3)
            3'd0:          result = prod[WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:          result = prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:    result = sign_q ? -lo_n : lo_n;
            default:       result = sign_r ? -hi_n : hi_n;
        endcase
    end

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            f3     <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            b      <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            f3     <= funct3;
            sign_q <= (a_neg ^ b_neg) && (op2 != '0);
            sign_r <= a_neg;
            hi     <= '0;
            lo     <= a_mag;
            b      <= b_mag;
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer execution unit with registered outputs and valid/ready on both sides.
// Define ALU_MULDIV_EN to build in the iterative RV32M multiply/divide path.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [4:0]       i_Operation,
    input  logic [WIDTH-1:0] i_Op1,
    input  logic [WIDTH-1:0] i_Op2,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Zero,
    output logic             o_Illegal
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t           state, state_next, issue_state;
    logic             accept, take_m, alu_legal;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res, result_q;
    logic             zero_q, illegal_q;

    // Handshake: a request transfers on a rising edge where i_Valid & o_Ready; a result
    // transfers where o_Valid & i_Ready. Neither side may retract while the other is low.
    assign accept = i_Valid & o_Ready;
    assign sh     = i_Op2[SHW-1:0];

`ifdef ALU_MULDIV_EN
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign take_m = is_m_op(i_Operation);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (i_Clk),
        .rst_n  (i_Rst_n),
        .start  (accept & take_m),
        .funct3 (i_Operation[2:0]),
        .op1    (i_Op1),
        .op2    (i_Op2),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign take_m = 1'b0;
`endif

    always_comb begin
        alu_legal = is_base_op(i_Operation);
        case (i_Operation)
            ALU_ADD:  alu_res = i_Op1 + i_Op2;
            ALU_SUB:  alu_res = i_Op1 - i_Op2;
            ALU_SLL:  alu_res = i_Op1 << sh;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_Op1) < $signed(i_Op2))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_Op1 < i_Op2)};
            ALU_XOR:  alu_res = i_Op1 ^ i_Op2;
            ALU_SRL:  alu_res = i_Op1 >> sh;
            ALU_SRA:  alu_res = $signed(i_Op1) >>> sh;
            ALU_OR:   alu_res = i_Op1 | i_Op2;
            ALU_AND:  alu_res = i_Op1 & i_Op2;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        issue_state = take_m ? ST_BUSY : ST_DONE;
        state_next  = state;
        case (state)
            ST_IDLE: if (accept) state_next = issue_state;
`ifdef ALU_MULDIV_EN
            ST_BUSY: if (md_done) state_next = ST_DONE;
`endif
            ST_DONE: if (i_Ready) state_next = accept ? issue_state : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_Ready = 1'b0;
        o_Valid = 1'b0;
        case (state)
            ST_IDLE: o_Ready = 1'b1;
            ST_DONE: begin
                o_Valid = 1'b1;
                o_Ready = i_Ready;
            end
            default: ;
        endcase
    end

    // Outputs only move when a new result is produced, so they hold under backpressure.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (accept && !take_m) begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= ~alu_legal;
        end
`ifdef ALU_MULDIV_EN
        else if (md_done) begin
            result_q  <= md_result;
            zero_q    <= (md_result == '0);
            illegal_q <= 1'b0;
        end
`endif
    end

    assign o_Result  = result_q;
    assign o_Zero    = zero_q;
    assign o_Illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, handshake corner cases and
// randomized requests compared against an arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         i_Clk = 1'b0;
    logic         i_Rst_n, i_Valid, i_Ready;
    logic         o_Ready, o_Valid, o_Zero, o_Illegal;
    logic [4:0]   i_Operation;
    logic [W-1:0] i_Op1, i_Op2, o_Result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ill;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           lat;
    } exp_t;

    alu_mc #(.WIDTH(W)) dut (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_Valid     (i_Valid),
        .o_Ready     (o_Ready),
        .i_Operation (i_Operation),
        .i_Op1       (i_Op1),
        .i_Op2       (i_Op2),
        .o_Valid     (o_Valid),
        .i_Ready     (i_Ready),
        .o_Result    (o_Result),
        .o_Zero      (o_Zero),
        .o_Illegal   (o_Illegal)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic ill);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = 0;
        return v;
    endfunction

    // M-op vectors only produce results when the mul/div path is built in.
    function automatic vec_t mk_m(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] res);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
`ifdef ALU_MULDIV_EN
        v.res = res; v.ill = 1'b0; v.lat = W;
`else
        v.res = '0; v.ill = 1'b1; v.lat = 0;
        if (res == '0) v.res = res;
`endif
        return v;
    endfunction

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        longint sa, sb, ua, ub, pw, q;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = int'(b % 32);
        pw = longint'(1) << sh;
        r.res = '0; r.ill = 1'b0; r.lat = 0;
        case (op)
            ALU_ADD:  r.res = W'(ua + ub);
            ALU_SUB:  r.res = W'(ua - ub);
            ALU_SLL:  r.res = W'(ua * pw);
            ALU_SLT:  r.res = (sa < sb) ? 1 : 0;
            ALU_SLTU: r.res = (ua < ub) ? 1 : 0;
            ALU_XOR:  r.res = a ^ b;
            ALU_SRL:  r.res = W'(ua / pw);
            ALU_SRA: begin
                q = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw);
                r.res = W'(q);
            end
            ALU_OR:   r.res = a | b;
            ALU_AND:  r.res = a & b;
            default: begin
                r.ill = 1'b1;
`ifdef ALU_MULDIV_EN
                if (op[4:3] == 2'b10) begin
                    logic [63:0] p;
                    r.ill = 1'b0;
                    r.lat = W;
                    case (op)
                        ALU_MUL:    begin p = 64'(sa * sb); r.res = p[31:0]; end
                        ALU_MULH:   begin p = 64'(sa * sb); r.res = p[63:32]; end
                        ALU_MULHSU: begin p = 64'(sa * ub); r.res = p[63:32]; end
                        ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r.res = p[63:32]; end
                        ALU_DIV:  r.res = (b == 0) ? ONES : ((a == MINV && b == ONES) ? MINV : W'(sa / sb));
                        ALU_REM:  r.res = (b == 0) ? a : ((a == MINV && b == ONES) ? '0 : W'(sa % sb));
                        ALU_DIVU: r.res = (b == 0) ? ONES : a / b;
                        default:  r.res = (b == 0) ? a : a % b;
                    endcase
                end
`endif
            end
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return ONES;
            2:       return MINV;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic ill, input int lat,
                          input int stall, input string tag);
        logic [W:0]   e;
        logic [W-1:0] held;
        int cyc, guard;
        bit ready_low, stable;
        exp_q.push_back({ill, res});
        i_Operation = op; i_Op1 = a; i_Op2 = b; i_Valid = 1'b1; i_Ready = 1'b1;
        #1;
        guard = 0;
        while (o_Ready !== 1'b1 && guard < 100) begin
            @(posedge i_Clk); #2;
            guard++;
        end
        check_int({tag, " accept_wait"}, guard, 0);
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        i_Operation = 5'($urandom); i_Op1 = $urandom; i_Op2 = $urandom;
        cyc = 0;
        ready_low = 1'b1;
        while (o_Valid !== 1'b1 && cyc < 100) begin
            if (o_Ready !== 1'b0) ready_low = 1'b0;
            @(posedge i_Clk); #1;
            cyc++;
        end
        e = exp_q.pop_front();
        check_val({tag, " result"}, o_Result, e[W-1:0]);
        check_val({tag, " zero"}, W'(o_Zero), W'(e[W-1:0] == '0));
        check_val({tag, " illegal"}, W'(o_Illegal), W'(e[W]));
        check_int({tag, " latency"}, cyc, lat);
        if (lat > 0) check_int({tag, " ready_low"}, int'(ready_low), 1);
        if (stall > 0) begin
            held = o_Result;
            stable = 1'b1;
            i_Ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                @(posedge i_Clk); #1;
                if (o_Valid !== 1'b1 || o_Result !== held) stable = 1'b0;
            end
            check_int({tag, " hold"}, int'(stable), 1);
            i_Ready = 1'b1;
        end
    endtask

    initial begin
        vec_t tbl[$];
        exp_t m;
        logic [4:0] op;
        logic [W-1:0] a, b;
        int seen;
        bit stable;

        i_Rst_n = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
        i_Operation = '0; i_Op1 = '0; i_Op2 = '0;
        repeat (3) @(posedge i_Clk);
        #1;
        check_val("rst valid", W'(o_Valid), 0);
        check_val("rst ready", W'(o_Ready), 1);
        check_val("rst result", o_Result, 0);
        check_val("rst zero", W'(o_Zero), 1);
        check_val("rst illegal", W'(o_Illegal), 0);
        i_Rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(posedge i_Clk); #1;
            if (o_Valid !== 1'b0 || o_Ready !== 1'b1) seen++;
        end
        check_int("idle no change", seen, 0);

        tbl.push_back(mk(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0));
        tbl.push_back(mk(ALU_SUB,  32'h5,         32'h5,         32'h0,         1'b0));
        tbl.push_back(mk(ALU_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0));
        tbl.push_back(mk(ALU_SRL,  32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0));
        tbl.push_back(mk(ALU_SLL,  32'h3,         32'h21,        32'h6,         1'b0));
        tbl.push_back(mk(ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0));
        tbl.push_back(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0));
        tbl.push_back(mk(ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0));
        tbl.push_back(mk(ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0));
        tbl.push_back(mk(ALU_AND,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0,         1'b0));
        tbl.push_back(mk(5'h0A,    32'h1,         32'h2,         32'h0,         1'b1));
        tbl.push_back(mk(5'h1F,    32'h1,         32'h2,         32'h0,         1'b1));
        tbl.push_back(mk_m(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001));
        tbl.push_back(mk_m(ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000));
        tbl.push_back(mk_m(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
        tbl.push_back(mk_m(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        tbl.push_back(mk_m(ALU_DIV,    32'h7,         32'h0,         32'hFFFF_FFFF));
        tbl.push_back(mk_m(ALU_REM,    32'h7,         32'h0,         32'h7));
        tbl.push_back(mk_m(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        tbl.push_back(mk_m(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(mk_m(ALU_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD));
        tbl.push_back(mk_m(ALU_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF));
        tbl.push_back(mk_m(ALU_DIV,    32'hFFFF_FFFA, 32'h0,         32'hFFFF_FFFF));
        tbl.push_back(mk_m(ALU_REM,    32'hFFFF_FFFA, 32'h0,         32'hFFFF_FFFA));
        tbl.push_back(mk_m(ALU_DIVU,   32'd100,       32'd7,         32'd14));
        tbl.push_back(mk_m(ALU_REMU,   32'd100,       32'd7,         32'd2));
        tbl.push_back(mk_m(ALU_DIVU,   32'h7,         32'h0,         32'hFFFF_FFFF));
        tbl.push_back(mk_m(ALU_REMU,   32'h7,         32'h0,         32'h7));

        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ill, tbl[i].lat,
                   (i % 4 == 3) ? 2 : 0, $sformatf("vec%0d", i));

        // Backpressure: result held, new request waits until i_Ready rises.
        i_Operation = ALU_ADD; i_Op1 = 32'd3; i_Op2 = 32'd4; i_Valid = 1'b1; i_Ready = 1'b1;
        #1;
        @(posedge i_Clk); #1;
        check_val("bp first result", o_Result, 32'd7);
        i_Operation = ALU_SUB; i_Op1 = 32'd10; i_Op2 = 32'd1; i_Ready = 1'b0;
        stable = 1'b1;
        repeat (3) begin
            #1;
            if (o_Ready !== 1'b0) stable = 1'b0;
            @(posedge i_Clk); #1;
            if (o_Valid !== 1'b1 || o_Result !== 32'd7 || o_Zero !== 1'b0 || o_Illegal !== 1'b0)
                stable = 1'b0;
        end
        check_int("bp hold", int'(stable), 1);
        i_Ready = 1'b1;
        #1;
        check_val("bp ready rises", W'(o_Ready), 1);
        @(posedge i_Clk); #1;
        check_val("bp second result", o_Result, 32'd9);
        check_val("bp second valid", W'(o_Valid), 1);
        i_Valid = 1'b0;
        @(posedge i_Clk); #1;
        check_val("bp drained", W'(o_Valid), 0);

        // Reset 10 cycles into a divide.
        i_Operation = ALU_DIV; i_Op1 = 32'd100; i_Op2 = 32'd7; i_Valid = 1'b1;
        #1;
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        repeat (9) @(posedge i_Clk);
        #1;
        i_Rst_n = 1'b0;
        @(posedge i_Clk); #1;
        check_val("midrst valid", W'(o_Valid), 0);
        check_val("midrst ready", W'(o_Ready), 1);
        i_Rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge i_Clk); #1;
            if (o_Valid !== 1'b0) seen++;
        end
        check_int("midrst no partial", seen, 0);
        run_op(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0, 0, "post-reset add");

        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            a = rand_operand();
            b = rand_operand();
            m = model(op, a, b);
            run_op(op, a, b, m.res, m.ill, m.lat, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised-width integer execution unit; the successor to the single-cycle combinational ALU in the execute stage. It adds registered outputs, a valid/ready handshake on both sides and an optional iterative RV32M multiply/divide path. The decode stage issues into it and writeback consumes from it; the pipeline stalls on `o_Ready` low.

## Interface
- `WIDTH`, default `WORD_SIZE` (32): operand and result width; must be ≥ 8 and a power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount bits taken from `i_Op2`. Derived; never overridden.

Ports:
- `i_Clk` in 1: sole clock; all state updates on its rising edge.
- `i_Rst_n` in 1: synchronous, active-low reset.
- `i_Valid` in 1: request present.
- `o_Ready` out 1: unit can accept a request this cycle.
- `i_Operation` in 5: operation code.
- `i_Op1` in WIDTH: operand 1.
- `i_Op2` in WIDTH: operand 2.
- `o_Valid` out 1: result present.
- `i_Ready` in 1: consumer takes the result.
- `o_Result` out WIDTH: registered result.
- `o_Zero` out 1: registered; high when `o_Result` == 0.
- `o_Illegal` out 1: registered; high when the operation code is unsupported.

## Operation
- Op code, bit4 = 0: bits[3:0] carry the existing `ALU_ADD` … `ALU_AND` codes, unchanged.
- Op code, bit4 = 1: M-extension op; bits[2:0] = funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Any other code is illegal: result 0, `o_Illegal` = 1, single-cycle latency.
- Shifts use `i_Op2[SHW-1:0]`. SRA is a true arithmetic shift: sign bit replicated.
- SLT/SLTU produce 0 or 1, zero-extended to WIDTH.
- Accept condition: `i_Valid & o_Ready`. Operands and op code are captured on the accept edge; inputs are don't-care afterwards.
- FSM states:
  - IDLE: `o_Ready` = 1.
  - BUSY: mul/div iterating; `o_Ready` = 0.
  - DONE: `o_Valid` = 1; `o_Ready` = `i_Ready`.
- FSM transitions:
  - IDLE→DONE: accept of a single-cycle op.
  - IDLE→BUSY: accept of an M op.
  - BUSY→DONE: iteration counter reaches WIDTH.
  - DONE→IDLE: `i_Ready` and no new accept.
  - DONE→DONE or DONE→BUSY: `i_Ready` together with a new accept (back-to-back).
- Multiply: radix-2 shift-add, one bit per cycle, 2·WIDTH-bit product.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide: restoring, one bit per cycle, on magnitudes; signs are fixed up in the final cycle.
- Divide by zero: DIV/DIVU = all ones; REM/REMU = dividend.
- Signed overflow (min ÷ −1): DIV = min; REM = 0.

## Timing
- Reset values: `o_Valid` = 0, `o_Ready` = 1 (IDLE), `o_Result` = 0, `o_Zero` = 1, `o_Illegal` = 0; iteration counter = 0.
- Latency, single-cycle op: 1. Accept at edge N, `o_Valid` high after edge N.
- Latency, M op: WIDTH+1, i.e. 33 cycles at WIDTH = 32.
- Throughput: one single-cycle op per clock while `i_Ready` stays high.
- Backpressure: while `o_Valid & ~i_Ready`, `o_Result`, `o_Zero` and `o_Illegal` hold stable and no request is accepted.
- Reset mid-operation (BUSY or DONE): the operation is aborted and the FSM returns to IDLE. `o_Valid` is 0 the cycle after the reset edge, and no partial result is ever presented.
- `i_Valid` low while in IDLE: no state change.

## Configuration
- `ALU_MULDIV_EN` defined:
  - the M-extension datapath and BUSY state are compiled in;
  - M ops behave as described under Operation.
- `ALU_MULDIV_EN` not defined:
  - the datapath, BUSY state and counter are removed;
  - every bit4 = 1 code is illegal (result 0, `o_Illegal` = 1, latency 1);
  - `o_Ready` = ~`o_Valid` | `i_Ready`.

## Structure
- `ALU_CONTROL.vh`: gains the 5-bit M-op codes (`ALU_MUL` … `ALU_REMU`) and an `ALU_OP_W` width constant.
- `PARAMETERS.vh`: keeps `WORD_SIZE` as the WIDTH default.
- FSM state encodings: local parameters inside the block.
- One sub-module, `alu_muldiv`:
  - contains the iterative multiplier/divider, its counter and the sign fix-up;
  - handshake is a start pulse in, a done pulse out;
  - instantiated only under `ALU_MULDIV_EN`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 with `i_Ready` = 1 → one cycle later `o_Valid` = 1, `o_Result` = 0x80000000, `o_Zero` = 0; a back-to-back SUB 5 − 5 in the next cycle → `o_Result` = 0, `o_Zero` = 1.
- SRA 0x80000000 by `i_Op2` = 0x24 (shift amount 4) → 0xF8000000; SRL with the same operands → 0x08000000.
- MUL and MULH of 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001 and 0x00000000; MULHU with the same operands → 0xFFFFFFFE; each with `o_Valid` exactly 33 cycles after accept and `o_Ready` low throughout.
- DIV 7 ÷ 0 → 0xFFFFFFFF, REM 7 ÷ 0 → 7, DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000, REM → 0; DIV −7 ÷ 2 → −3, REM → −1.
- Backpressure: `i_Ready` held low 3 cycles after a result appears, with `i_Valid` high on a new request → outputs stable, no accept until the cycle `i_Ready` rises.
- Reset asserted 10 cycles into a DIV → `o_Valid` = 0 and `o_Ready` = 1 after the reset edge; a subsequent ADD completes normally.
- Build without `ALU_MULDIV_EN` → MUL request returns result 0, `o_Illegal` = 1, latency 1.
